mcast_tx_port: RTL and testbench

MCAST_TX_PORT -- requirements
Module: mcast_tx_port

---
 rtl/mcast_tx_port.sv | 98 +++++++++
 tb/tb_mcast_tx_port.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mcast_tx_port.sv
// Multicast crossbar transmit port: buffers flits in a FIFO and keeps the head flit
// on the crossbar until every destination in its mask has acknowledged it.
module mcast_tx_port #(
  parameter int PORTS = 2,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [PORTS-1:0]           in_dest,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           xb_data,
  output logic [PORTS-1:0]           xb_dest,
  input  logic [PORTS-1:0]           ack,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PORTS-1:0] pending;
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [PORTS-1:0] dest_mem [DEPTH];

  logic             push;
  logic             retire;
  logic [PORTS-1:0] remain;

  // in_ready looks at level only, so a retire never opens a slot in the same cycle.
  assign in_ready = rst_n && (level < LW'(DEPTH));
  assign push     = in_valid && in_ready && (in_dest != '0);
  assign remain   = pending & ~ack;
  assign retire   = (state == SEND) && (remain == '0);

  assign xb_data  = (state == SEND) ? data_mem[rd_ptr] : '0;
  assign xb_dest  = (state == SEND) ? pending : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= in_data;
      dest_mem[wr_ptr] <= in_dest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      pending <= '0;
      level   <= '0;
      done    <= 1'b0;
    end else begin
      done <= retire;
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (retire) rd_ptr <= rd_ptr + PW'(1);
      case ({push, retire})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      case (state)
        IDLE: begin
          if (push) begin
            state   <= SEND;
            pending <= in_dest;
          end
        end
        SEND: begin
          // The next head comes from the FIFO if one is stored, else straight from a same-cycle push.
          if (!retire) begin
            pending <= remain;
          end else if (level > LW'(1)) begin
            pending <= dest_mem[rd_ptr + PW'(1)];
          end else if (push) begin
            pending <= in_dest;
          end else begin
            state   <= IDLE;
            pending <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcast_tx_port.sv
// Bench for mcast_tx_port: directed scenarios plus random traffic, all compared
// against a queue-based model of the multicast FIFO.
module tb_mcast_tx_port;

  localparam int P  = 2;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic [P-1:0]  in_dest;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  xb_data;
  logic [P-1:0]  xb_dest;
  logic [P-1:0]  ack;
  logic          done;
  logic [LW-1:0] level;

  mcast_tx_port #(.PORTS(P), .WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dest(in_dest),
    .in_valid(in_valid), .in_ready(in_ready), .xb_data(xb_data),
    .xb_dest(xb_dest), .ack(ack), .done(done), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic [P-1:0] dest;
  } flit_t;

  flit_t        q[$];
  logic [P-1:0] mPend;
  logic         mDone;
  int           passCount  = 0;
  int           totalCount = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Model of one clock edge: a flit whose mask is fully covered leaves; a new head
  // always starts with its full destination mask.
  task automatic modelEdge(input logic v, input logic [W-1:0] d, input logic [P-1:0] m,
                           input logic [P-1:0] a);
    bit wasEmpty = (q.size() == 0);
    bit rdy      = (q.size() < D);
    bit ret      = !wasEmpty && ((mPend & ~a) == '0);
    bit pushIt   = v && rdy && (m != '0);
    flit_t f;
    f.data = d;
    f.dest = m;
    if (ret) void'(q.pop_front());
    if (pushIt) q.push_back(f);
    mDone = ret;
    if (ret || wasEmpty) mPend = (q.size() != 0) ? q[0].dest : '0;
    else                 mPend = mPend & ~a;
  endtask

  task automatic checkOutput();
    check("xb_data", 32'(xb_data), (q.size() != 0) ? 32'(q[0].data) : 32'd0);
    check("xb_dest", 32'(xb_dest), (q.size() != 0) ? 32'(mPend) : 32'd0);
    check("done",    32'(done),    32'(mDone));
    check("level",   32'(level),   32'(q.size()));
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic [P-1:0] m,
                               input logic [P-1:0] a);
    in_valid = v;
    in_data  = d;
    in_dest  = m;
    ack      = a;
    #1;
    check("in_ready", 32'(in_ready), (q.size() < D) ? 32'd1 : 32'd0);
    @(posedge clk);
    modelEdge(v, d, m, a);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic applyReset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_xb_dest",  32'(xb_dest),  32'd0);
    check("rst_xb_data",  32'(xb_data),  32'd0);
    check("rst_level",    32'(level),    32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    mPend = '0;
    mDone = 1'b0;
    @(negedge clk);
    checkOutput();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_dest  = '0;
    ack      = '0;
    mPend    = '0;
    mDone    = 1'b0;
    @(negedge clk);
    check("init_in_ready", 32'(in_ready), 32'd0);
    checkOutput();
    rst_n = 1'b1;

    // Unicast: one ack retires it.
    applyStimulus(1'b1, 8'hA5, 2'b01, 2'b00);
    check("uni_dest", 32'(xb_dest), 32'h1);
    check("uni_data", 32'(xb_data), 32'hA5);
    applyStimulus(1'b0, 8'h00, 2'b00, 2'b01);
    check("uni_done", 32'(done), 32'd1);
    check("uni_level", 32'(level), 32'd0);
    applyStimulus(1'b0, 8'h00, 2'b00, 2'b00);
    check("uni_done_clear", 32'(done), 32'd0);

    // Partial multicast acks.
    applyStimulus(1'b1, 8'h3C, 2'b11, 2'b00);
    check("mc_dest0", 32'(xb_dest), 32'h3);
    applyStimulus(1'b0, 8'h00, 2'b00, 2'b01);
    check("mc_dest1", 32'(xb_dest), 32'h2);
    check("mc_nodone", 32'(done), 32'd0);
    applyStimulus(1'b0, 8'h00, 2'b00, 2'b10);
    check("mc_dest2", 32'(xb_dest), 32'h0);
    check("mc_done", 32'(done), 32'd1);
    applyStimulus(1'b0, 8'h00, 2'b00, 2'b00);
    check("mc_done_once", 32'(done), 32'd0);

    // Back-to-back flits with ack always 11.
    applyStimulus(1'b1, 8'h11, 2'b01, 2'b11);
    check("b2b_first", 32'(xb_data), 32'h11);
    applyStimulus(1'b1, 8'h22, 2'b10, 2'b11);
    check("b2b_second", 32'(xb_data), 32'h22);
    check("b2b_done1", 32'(done), 32'd1);
    applyStimulus(1'b0, 8'h00, 2'b00, 2'b11);
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_level", 32'(level), 32'd0);

    // Full FIFO: four pushes with no acks, then one full ack.
    for (int i = 0; i < D; i++) applyStimulus(1'b1, 8'(8'h40 + i), 2'b01, 2'b00);
    check("full_level", 32'(level), 32'd4);
    check("full_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 8'hEE, 2'b11, 2'b01);
    check("full_level_after", 32'(level), 32'd3);
    check("full_ready_after", 32'(in_ready), 32'd1);
    check("full_next_head", 32'(xb_data), 32'h41);
    for (int i = 0; i < D; i++) applyStimulus(1'b0, 8'h00, 2'b00, 2'b11);

    // Zero destination is discarded.
    applyStimulus(1'b1, 8'h77, 2'b00, 2'b00);
    check("zero_level", 32'(level), 32'd0);
    check("zero_dest", 32'(xb_dest), 32'd0);
    applyStimulus(1'b0, 8'h00, 2'b00, 2'b00);
    check("zero_nodone", 32'(done), 32'd0);

    // Reset with three flits held and the head partially served.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h90 + i), 2'b11, 2'b00);
    applyStimulus(1'b0, 8'h00, 2'b00, 2'b01);
    check("pre_rst_level", 32'(level), 32'd3);
    applyReset();
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 8'h00, 2'b00, 2'b11);
    check("post_rst_level", 32'(level), 32'd0);
    check("post_rst_dest", 32'(xb_dest), 32'd0);
    applyStimulus(1'b1, 8'h5A, 2'b10, 2'b00);
    check("post_rst_push", 32'(level), 32'd1);

    // Random traffic, with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) applyReset();
      applyStimulus(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 8'($urandom),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
